// File: rtl/iic_pkg.sv
// iic_pkg: configuration entry layout, marker codes, sequencer states and counter sizing.
package iic_pkg;
  localparam int SLV_W = 7;
  localparam int REG_W = 8;
  localparam int DAT_W = 8;
  localparam int ENTRY_W = SLV_W + REG_W + DAT_W;
  localparam logic [SLV_W-1:0] END_MARK = 7'h7F;
  localparam logic [SLV_W-1:0] DELAY_MARK = 7'h7E;
  typedef struct packed {
    logic [SLV_W-1:0] slv;
    logic [REG_W-1:0] rga;
    logic [DAT_W-1:0] dat;
  } entry_t;
  typedef enum logic [2:0] {IDLE, FETCH, ISSUE, WAIT_BUSY, WAIT_DONE, GAP, DELAY, DONE} state_t;
  function automatic int cnt_width(int a, int b, int c);
    int m;
    m = a > b ? a : b;
    m = m > c ? m : c;
    return $clog2(m + 1);
  endfunction
endpackage

// File: rtl/iic_cfg_rom.sv
// iic_cfg_rom: board configuration table; three writes, a 2-unit delay, one more write, then END.
module iic_cfg_rom
  import iic_pkg::*;
#(
  parameter int IW = 4
)(
  input  logic [IW-1:0] idx,
  output entry_t        entry
);
  always_comb
    case (32'(idx))
      0:       entry = {7'h4B, 8'h36, 8'hC2};
      1:       entry = {7'h1A, 8'h10, 8'h55};
      2:       entry = {7'h2C, 8'h21, 8'hAA};
      3:       entry = {DELAY_MARK, 8'h00, 8'h02};
      4:       entry = {7'h3D, 8'h44, 8'h0F};
      default: entry = {END_MARK, 8'h00, 8'h00};
    endcase
endmodule

// File: rtl/iic_cfg_sequencer.sv
// iic_cfg_sequencer: walks the configuration ROM and feeds one write at a time to iic_master.
module iic_cfg_sequencer
  import iic_pkg::*;
#(
  parameter int NUM_ENTRIES = 16,
  parameter int GAP_CYCLES = 100,
  parameter int DELAY_UNIT = 50000,
  parameter int ACK_TIMEOUT = 1000,
  localparam int IW = NUM_ENTRIES > 1 ? $clog2(NUM_ENTRIES) : 1
)(
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          start_i,
  input  logic          ready_i,
  output logic          flag_o,
  output logic [6:0]    Slv_Addr_o,
  output logic [7:0]    Reg_Addr_o,
  output logic [7:0]    Data_o,
  output logic          busy_o,
  output logic          done_o,
  output logic          err_o,
  output logic [IW-1:0] idx_o
);
  localparam int CW = cnt_width(255 * DELAY_UNIT, GAP_CYCLES, ACK_TIMEOUT);
  state_t state, nxt;
  entry_t entry;
  logic [CW-1:0] cnt;
  logic last, gap_done, dly_done, ack_to;
  iic_cfg_rom #(.IW(IW)) u_rom (.idx(idx_o), .entry(entry));
  assign last = idx_o == IW'(NUM_ENTRIES - 1);
  assign gap_done = int'(cnt) >= GAP_CYCLES - 1;
  assign dly_done = int'(cnt) + 1 >= int'(entry.dat) * DELAY_UNIT;
  assign ack_to = int'(cnt) >= ACK_TIMEOUT - 1;
  assign busy_o = state != IDLE;
  assign done_o = state == DONE;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:      nxt = start_i ? FETCH : IDLE;
      FETCH:     nxt = entry.slv == END_MARK ? DONE : entry.slv == DELAY_MARK ? DELAY : ISSUE;
      ISSUE:     nxt = ready_i ? WAIT_BUSY : ISSUE;
      WAIT_BUSY: nxt = !ready_i ? WAIT_DONE : ack_to ? IDLE : WAIT_BUSY;
      WAIT_DONE: nxt = ready_i ? GAP : WAIT_DONE;
      GAP:       nxt = gap_done ? (last ? DONE : FETCH) : GAP;
      DELAY:     nxt = dly_done ? (last ? DONE : FETCH) : DELAY;
      default:   nxt = IDLE;
    endcase
  end
  // flag is registered so the address/data latched in FETCH are stable a full cycle before it
  always_ff @(posedge clk_i)
    if (reset_i) begin
      state <= IDLE;
      cnt <= '0;
      idx_o <= '0;
      flag_o <= 1'b0;
      err_o <= 1'b0;
      Slv_Addr_o <= '0;
      Reg_Addr_o <= '0;
      Data_o <= '0;
    end else begin
      state <= nxt;
      cnt <= (nxt == state && (state == GAP || state == DELAY || state == WAIT_BUSY)) ? cnt + 1'b1 : '0;
      flag_o <= state == ISSUE && ready_i;
      if (state == IDLE && start_i) begin
        idx_o <= '0;
        err_o <= 1'b0;
      end
      if ((state == GAP || state == DELAY) && nxt == FETCH)
        idx_o <= idx_o + 1'b1;
      if (state == WAIT_BUSY && nxt == IDLE)
        err_o <= 1'b1;
      if (state == FETCH && nxt == ISSUE)
        {Slv_Addr_o, Reg_Addr_o, Data_o} <= entry;
    end
endmodule

// File: doc/iic_cfg_sequencer.md
Name: iic_cfg_sequencer

Overview:
- Upstream command source for iic_master.
- Walks a fixed configuration table of (slave address, register address, data) write entries.
- Issues one flag pulse per entry, then waits for the master to finish before advancing.
- Sits between system control (start/done) and the iic_master command inputs; used for power-up sensor/codec initialisation.

Parameters:
- NUM_ENTRIES, 16, table depth; index width is clog2(NUM_ENTRIES).
- GAP_CYCLES, 100, idle clk_i cycles inserted after each completed write before the next issue.
- DELAY_UNIT, 50000, clk_i cycles per unit of a delay entry (1 ms at 50 MHz).
- ACK_TIMEOUT, 1000, max cycles for ready_i to fall after a flag_o pulse.

Ports:
- clk_i  in  1  system clock, 50 MHz
- reset_i  in  1  synchronous, active-high reset
- start_i  in  1  single-cycle pulse; begins the sequence from entry 0
- ready_i  in  1  from iic_master ready_o; high = master idle
- flag_o  out  1  to iic_master flag_i; one-cycle issue pulse
- Slv_Addr_o  out  7  to iic_master Slv_Addr_i
- Reg_Addr_o  out  8  to iic_master Reg_Addr_i
- Data_o  out  8  to iic_master Data_i
- busy_o  out  1  sequence in progress
- done_o  out  1  one-cycle pulse on successful completion
- err_o  out  1  sticky timeout flag; cleared by reset_i or start_i
- idx_o  out  clog2(NUM_ENTRIES)  index of current/last entry

Behaviour:
- Reset is synchronous, active-high, one clock. Reset values:
  - flag_o, busy_o, done_o, err_o = 0
  - Slv_Addr_o, Reg_Addr_o, Data_o = 0
  - idx_o = 0
  - state = IDLE
- Reset mid-sequence aborts immediately. No further flag_o pulses.
- Table entries are 23 bits {slv[6:0], reg[7:0], dat[7:0]}, supplied combinationally by the ROM from idx.
- Special entries:
  - slv = 7'h7F: END marker.
  - slv = 7'h7E: DELAY of dat*DELAY_UNIT cycles. dat = 0 means no delay.
  - Reaching idx = NUM_ENTRIES-1 without an END marker ends the sequence after that entry.
- States:
  - IDLE: busy_o = 0. On start_i: idx <= 0, err_o <= 0, go to FETCH.
  - FETCH: decode the entry (one cycle).
    - END → DONE.
    - DELAY → DELAY.
    - Otherwise latch the three output registers and go to ISSUE.
  - ISSUE: wait for ready_i = 1. Assert flag_o for exactly one cycle with address/data outputs already stable (latched ≥1 cycle earlier). Go to WAIT_BUSY.
  - WAIT_BUSY: wait for ready_i = 0, then go to WAIT_DONE. If ACK_TIMEOUT cycles elapse without ready_i falling, set err_o and go to IDLE.
  - WAIT_DONE: wait for ready_i = 1 (no timeout), then go to GAP.
  - GAP: count GAP_CYCLES. Then, if idx = NUM_ENTRIES-1, go to DONE; else idx <= idx+1 and go to FETCH.
  - DELAY: count dat*DELAY_UNIT cycles. Then advance idx as in GAP.
  - DONE: done_o = 1 for one cycle, then go to IDLE.
- busy_o = 1 in every state except IDLE.
- Slv_Addr_o, Reg_Addr_o, Data_o hold their last value outside FETCH; they never change while in WAIT_BUSY or WAIT_DONE.
- start_i is ignored while busy_o = 1.
- Counters are sized for the largest product, 255*DELAY_UNIT. Overflow is not permitted.

Decomposition:
- Shared package iic_pkg:
  - entry field widths and slices
  - END_MARK = 7'h7F, DELAY_MARK = 7'h7E
  - state encoding constants
- Sub-module iic_cfg_rom:
  - pure combinational case on idx returning the 23-bit entry
  - out-of-range idx returns END
  - swapped per board.

Test Plan:
1. Entry0 = {7'h4B, 8'h36, 8'hC2}, entry1 = END; pulse start_i; model master drops ready_i 2 cycles after flag_o and raises it 500 cycles later → exactly one flag_o pulse with outputs 4B/36/C2 stable from the prior cycle; done_o one cycle, 1 + GAP_CYCLES + 1 cycles after ready_i rises.
2. Three write entries then END → three flag_o pulses; idx_o reads 0, 1, 2; pulse spacing ≥ GAP_CYCLES after each ready_i rise; single done_o pulse.
3. DELAY entry with dat = 2, DELAY_UNIT set to 10 → 20-cycle wait between the adjacent writes; no flag_o during the delay.
4. Model master never drops ready_i → err_o = 1 exactly ACK_TIMEOUT cycles after flag_o; busy_o = 0; no done_o. A new start_i clears err_o.
5. Assert reset_i during WAIT_DONE → next cycle all outputs are at reset values; no flag_o until a new start_i.
6. start_i pulsed while busy_o = 1 → ignored; idx_o is unaffected and the sequence completes normally.
